// File: rtl/color_window_stats_if.sv
// Pixel stream in and per-pixel mask stream out for color_window_stats.
// The source drives the in_* side and the classifier drives the mask_* side.
interface color_window_stats_if #(
    parameter int CW = 4,
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          in_valid;
    logic [3*CW-1:0] in_pix;
    logic          in_sof;
    logic          in_eol;
    logic          in_eof;
    logic          mask_valid;
    logic          mask;
    logic [XW-1:0] mask_x;
    logic [YW-1:0] mask_y;

    modport master (
        output in_valid, in_pix, in_sof, in_eol, in_eof,
        input  mask_valid, mask, mask_x, mask_y
    );

    modport slave (
        input  in_valid, in_pix, in_sof, in_eol, in_eof,
        output mask_valid, mask, mask_x, mask_y
    );
endinterface

// File: rtl/color_window_stats.sv
// Streaming RGB window classifier: per-pixel mask with 2-cycle latency plus
// per-frame hit count and bounding box, with window bounds latched at each sof.
module color_window_stats #(
    parameter int CW = 4,
    parameter int XW = 10,
    parameter int YW = 10,
    parameter int NW = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    color_window_stats_if.slave  stream,
    input  logic [7:0]           r_min,
    input  logic [7:0]           r_max,
    input  logic [7:0]           g_min,
    input  logic [7:0]           g_max,
    input  logic [7:0]           b_min,
    input  logic [7:0]           b_max,
    output logic                 stat_valid,
    output logic [NW-1:0]        stat_count,
    output logic [XW-1:0]        stat_xmin,
    output logic [XW-1:0]        stat_xmax,
    output logic [YW-1:0]        stat_ymin,
    output logic [YW-1:0]        stat_ymax,
    output logic                 stat_empty,
    output logic                 frame_abort
);
    localparam int REP = (8 + CW - 1) / CW;

    typedef enum logic {IDLE, ACTIVE} state_t;

    // Replicate the channel MSB-first and keep the top byte, so full scale maps to 0xFF.
    function automatic logic [7:0] expand(input logic [CW-1:0] c);
        logic [CW*REP-1:0] rep;
        rep = {REP{c}};
        return rep[CW*REP-1 -: 8];
    endfunction

    state_t        state;
    logic [XW-1:0] x_last, x_cur;
    logic [YW-1:0] y_last, y_cur;
    logic          eol_pend;
    logic [7:0]    r_lo, r_hi, g_lo, g_hi, b_lo, b_hi;

    logic          s1_valid, s1_start, s1_acc, s1_fin;
    logic [7:0]    s1_r, s1_g, s1_b;
    logic [XW-1:0] s1_x;
    logic [YW-1:0] s1_y;

    logic          s2_fin;
    logic [NW-1:0] acc_count, nxt_count;
    logic [XW-1:0] acc_xmin, acc_xmax, nxt_xmin, nxt_xmax;
    logic [YW-1:0] acc_ymin, acc_ymax, nxt_ymin, nxt_ymax;
    logic          hit;

    logic frame_start, frame_acc, frame_end;

    assign frame_start = stream.in_valid & stream.in_sof;
    assign frame_acc   = stream.in_valid & (stream.in_sof | (state == ACTIVE));
    assign frame_end   = stream.in_valid & stream.in_eof & (stream.in_sof | (state == ACTIVE));

    always_comb begin
        x_cur = x_last;
        y_cur = y_last;
        if (stream.in_sof) begin
            x_cur = '0;
            y_cur = '0;
        end else if (eol_pend) begin
            x_cur = '0;
            y_cur = (y_last == '1) ? y_last : y_last + 1'b1;
        end else begin
            x_cur = (x_last == '1) ? x_last : x_last + 1'b1;
        end
    end

    // Input stage: frame FSM, coordinate tracking, window shadows and stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            frame_abort <= 1'b0;
            x_last      <= '0;
            y_last      <= '0;
            eol_pend    <= 1'b0;
            r_lo        <= '0;
            r_hi        <= '0;
            g_lo        <= '0;
            g_hi        <= '0;
            b_lo        <= '0;
            b_hi        <= '0;
            s1_valid    <= 1'b0;
            s1_start    <= 1'b0;
            s1_acc      <= 1'b0;
            s1_fin      <= 1'b0;
            s1_r        <= '0;
            s1_g        <= '0;
            s1_b        <= '0;
            s1_x        <= '0;
            s1_y        <= '0;
        end else begin
            frame_abort <= frame_start & ~stream.in_eof & (state == ACTIVE);
            s1_valid    <= stream.in_valid;
            s1_start    <= frame_start;
            s1_acc      <= frame_acc;
            s1_fin      <= frame_end;
            if (stream.in_valid) begin
                x_last   <= x_cur;
                y_last   <= y_cur;
                eol_pend <= stream.in_eol;
                s1_r     <= expand(stream.in_pix[3*CW-1:2*CW]);
                s1_g     <= expand(stream.in_pix[2*CW-1:CW]);
                s1_b     <= expand(stream.in_pix[CW-1:0]);
                s1_x     <= x_cur;
                s1_y     <= y_cur;
            end
            if (frame_start) begin
                r_lo <= r_min;
                r_hi <= r_max;
                g_lo <= g_min;
                g_hi <= g_max;
                b_lo <= b_min;
                b_hi <= b_max;
            end
            case (state)
                IDLE:   if (frame_start && !stream.in_eof) state <= ACTIVE;
                ACTIVE: if (stream.in_valid && stream.in_eof) state <= IDLE;
            endcase
        end
    end

    assign hit = (r_lo <= s1_r) && (s1_r <= r_hi) &&
                 (g_lo <= s1_g) && (s1_g <= g_hi) &&
                 (b_lo <= s1_b) && (s1_b <= b_hi);

    // A sof pixel restarts the accumulators before its own hit is folded in.
    always_comb begin
        nxt_count = s1_start ? '0 : acc_count;
        nxt_xmin  = s1_start ? '1 : acc_xmin;
        nxt_xmax  = s1_start ? '0 : acc_xmax;
        nxt_ymin  = s1_start ? '1 : acc_ymin;
        nxt_ymax  = s1_start ? '0 : acc_ymax;
        if (s1_acc && hit) begin
            nxt_count = (nxt_count == '1) ? nxt_count : nxt_count + 1'b1;
            if (s1_x < nxt_xmin) nxt_xmin = s1_x;
            if (s1_x > nxt_xmax) nxt_xmax = s1_x;
            if (s1_y < nxt_ymin) nxt_ymin = s1_y;
            if (s1_y > nxt_ymax) nxt_ymax = s1_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stream.mask_valid <= 1'b0;
            stream.mask       <= 1'b0;
            stream.mask_x     <= '0;
            stream.mask_y     <= '0;
            s2_fin            <= 1'b0;
            acc_count         <= '0;
            acc_xmin          <= '1;
            acc_xmax          <= '0;
            acc_ymin          <= '1;
            acc_ymax          <= '0;
            stat_valid        <= 1'b0;
            stat_count        <= '0;
            stat_xmin         <= '1;
            stat_xmax         <= '0;
            stat_ymin         <= '1;
            stat_ymax         <= '0;
            stat_empty        <= 1'b0;
        end else begin
            stream.mask_valid <= s1_valid;
            stream.mask       <= s1_valid & hit;
            stream.mask_x     <= s1_x;
            stream.mask_y     <= s1_y;
            s2_fin            <= s1_valid & s1_fin;
            if (s1_valid && s1_acc) begin
                acc_count <= nxt_count;
                acc_xmin  <= nxt_xmin;
                acc_xmax  <= nxt_xmax;
                acc_ymin  <= nxt_ymin;
                acc_ymax  <= nxt_ymax;
            end
            // The report samples the accumulators before a back-to-back sof overwrites them.
            stat_valid <= s2_fin;
            if (s2_fin) begin
                stat_count <= acc_count;
                stat_xmin  <= acc_xmin;
                stat_xmax  <= acc_xmax;
                stat_ymin  <= acc_ymin;
                stat_ymax  <= acc_ymax;
                stat_empty <= (acc_count == '0);
            end
        end
    end
endmodule
